// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: FSM state encoding,
// requester owner ID and the default decode-info width.

`ifndef DECODE_INFO_LEN
`define DECODE_INFO_LEN 32
`endif

package alu_arb_pkg;

    // Arbiter FSM states: wait for a request, drive the ALU, hold the result
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Identifies which requester owns the in-flight operation
    typedef enum logic {
        OWNER_0 = 1'b0,
        OWNER_1 = 1'b1
    } owner_e;

    // Last-grant pointer value after reset, so requester 0 wins first contention
    localparam owner_e PTR_RESET = OWNER_1;

    localparam int DEC_W_DEFAULT = `DECODE_INFO_LEN;

    // Convert a one-hot 2-bit grant into an owner ID
    function automatic owner_e grant_to_owner(input logic [1:0] grant);
        return grant[1] ? OWNER_1 : OWNER_0;
    endfunction

endpackage

// File: rtl/alu_arb_rr_arb2.sv
// Two-way round-robin grant: a lone valid requester always wins; on
// contention the requester that was not granted last wins.

module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  owner_e     last_i,
    output logic [1:0] grant_o
);

    // One-hot grant from the valid pair and the last-grant pointer
    always_comb begin
        grant_o = 2'b00;
        if (valid_i == 2'b11) begin
            grant_o = (last_i == OWNER_1) ? 2'b01 : 2'b10;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/alu_arb.sv
// Shares one external combinational ALU between two requesters.
// Each accepted operation takes IDLE -> EXEC -> RESP, with the result held
// in RESP until the owning requester accepts it.

`ifndef DECODE_INFO_LEN
`define DECODE_INFO_LEN 32
`endif

module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEC_W = `DECODE_INFO_LEN
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_rs1,
    input  logic [XLEN-1:0]  req0_rs2,
    input  logic [XLEN-1:0]  req0_imm,
    input  logic [DEC_W-1:0] req0_dec_info,
    input  logic             req0_alu,
    input  logic             req0_alui,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_rs1,
    input  logic [XLEN-1:0]  req1_rs2,
    input  logic [XLEN-1:0]  req1_imm,
    input  logic [DEC_W-1:0] req1_dec_info,
    input  logic             req1_alu,
    input  logic             req1_alui,

    output logic [XLEN-1:0]  op_rs1,
    output logic [XLEN-1:0]  op_rs2,
    output logic [XLEN-1:0]  exe_imm,
    output logic [DEC_W-1:0] exe_dec_info,
    output logic             exe_alu,
    output logic             exe_alui,
    input  logic [XLEN-1:0]  alu_result,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [XLEN-1:0]  rsp0_result,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [XLEN-1:0]  rsp1_result
);

    arb_state_e       state_q;
    owner_e           ptr_q;
    owner_e           owner_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [XLEN-1:0]  imm_q;
    logic [DEC_W-1:0] dec_q;
    logic             alu_q;
    logic             alui_q;
    logic [XLEN-1:0]  result_q;

    logic [1:0]       grant;
    logic             in_idle;
    logic             in_exec;
    logic             in_resp;
    logic             rsp_fire;

    owner_e           owner_d;
    logic [XLEN-1:0]  rs1_d;
    logic [XLEN-1:0]  rs2_d;
    logic [XLEN-1:0]  imm_d;
    logic [DEC_W-1:0] dec_d;
    logic             alu_d;
    logic             alui_d;

    rr_arb2 u_rr_arb2 (
        .valid_i ({req1_valid, req0_valid}),
        .last_i  (ptr_q),
        .grant_o (grant)
    );

    assign in_idle = (state_q == ST_IDLE);
    assign in_exec = (state_q == ST_EXEC);
    assign in_resp = (state_q == ST_RESP);

    assign req0_ready = in_idle & grant[0];
    assign req1_ready = in_idle & grant[1];

    // Select the granted requester's operation for capture (grant is one-hot)
    always_comb begin
        owner_d = grant_to_owner(grant);
        rs1_d   = grant[1] ? req1_rs1      : req0_rs1;
        rs2_d   = grant[1] ? req1_rs2      : req0_rs2;
        imm_d   = grant[1] ? req1_imm      : req0_imm;
        dec_d   = grant[1] ? req1_dec_info : req0_dec_info;
        alu_d   = grant[1] ? req1_alu      : req0_alu;
        alui_d  = grant[1] ? req1_alui     : req0_alui;
    end

    // The response completes only when the owner itself accepts it
    assign rsp_fire = (owner_q == OWNER_0) ? rsp0_ready : rsp1_ready;

    // Arbiter FSM: capture on grant, sample the ALU in EXEC, hold in RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RESET;
            owner_q  <= OWNER_0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            dec_q    <= '0;
            alu_q    <= 1'b0;
            alui_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        rs1_q   <= rs1_d;
                        rs2_q   <= rs2_d;
                        imm_q   <= imm_d;
                        dec_q   <= dec_d;
                        alu_q   <= alu_d;
                        alui_q  <= alui_d;
                        owner_q <= owner_d;
                        ptr_q   <= owner_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The shared ALU only sees operands while an operation is executing
    assign op_rs1       = in_exec ? rs1_q  : '0;
    assign op_rs2       = in_exec ? rs2_q  : '0;
    assign exe_imm      = in_exec ? imm_q  : '0;
    assign exe_dec_info = in_exec ? dec_q  : '0;
    assign exe_alu      = in_exec & alu_q;
    assign exe_alui     = in_exec & alui_q;

    assign rsp0_valid  = in_resp & (owner_q == OWNER_0);
    assign rsp1_valid  = in_resp & (owner_q == OWNER_1);
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: directed scenarios followed by random
// traffic, checked against a transaction-level round-robin/ALU model.

module tb_alu_arb;

    localparam int XLEN  = 32;
    localparam int DEC_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             req0_valid, req0_ready, req0_alu, req0_alui;
    logic [XLEN-1:0]  req0_rs1, req0_rs2, req0_imm;
    logic [DEC_W-1:0] req0_dec_info;
    logic             req1_valid, req1_ready, req1_alu, req1_alui;
    logic [XLEN-1:0]  req1_rs1, req1_rs2, req1_imm;
    logic [DEC_W-1:0] req1_dec_info;
    logic [XLEN-1:0]  op_rs1, op_rs2, exe_imm, alu_result;
    logic [DEC_W-1:0] exe_dec_info;
    logic             exe_alu, exe_alui;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0]  rsp0_result, rsp1_result;

    // Requester-side model state
    logic             reqValid [2];
    logic [XLEN-1:0]  mRs1 [2];
    logic [XLEN-1:0]  mRs2 [2];
    logic [XLEN-1:0]  mImm [2];
    logic [DEC_W-1:0] mDec [2];
    logic             mAlu [2];
    logic             mAlui [2];
    logic             rspRdy [2];
    int               lastGrant;
    int               assertCount;
    int               failCount;

    alu_arb #(.XLEN(XLEN), .DEC_W(DEC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm),
        .req0_dec_info(req0_dec_info), .req0_alu(req0_alu), .req0_alui(req0_alui),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm),
        .req1_dec_info(req1_dec_info), .req1_alu(req1_alu), .req1_alui(req1_alui),
        .op_rs1(op_rs1), .op_rs2(op_rs2), .exe_imm(exe_imm),
        .exe_dec_info(exe_dec_info), .exe_alu(exe_alu), .exe_alui(exe_alui),
        .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result)
    );

    // ALU semantics on the low three decode bits: ADD, SUB, XOR, OR, AND
    function automatic logic [XLEN-1:0] aluFn(input logic [2:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a ^ b;
            3'd3:    return a | b;
            3'd4:    return a & b;
            default: return '0;
        endcase
    endfunction

    // External ALU stand-in driven by the arbiter's shared outputs
    always_comb begin
        alu_result = '0;
        if (exe_alu) begin
            alu_result = aluFn(exe_dec_info[2:0], op_rs1, op_rs2);
        end else if (exe_alui) begin
            alu_result = aluFn(exe_dec_info[2:0], op_rs1, exe_imm);
        end
    end

    // Result a requester expects for its own pending request
    function automatic logic [XLEN-1:0] refResult(input int i);
        if (mAlu[i])  return aluFn(mDec[i][2:0], mRs1[i], mRs2[i]);
        if (mAlui[i]) return aluFn(mDec[i][2:0], mRs1[i], mImm[i]);
        return '0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        req0_valid = reqValid[0]; req0_rs1 = mRs1[0]; req0_rs2 = mRs2[0]; req0_imm = mImm[0];
        req0_dec_info = mDec[0]; req0_alu = mAlu[0]; req0_alui = mAlui[0];
        req1_valid = reqValid[1]; req1_rs1 = mRs1[1]; req1_rs2 = mRs2[1]; req1_imm = mImm[1];
        req1_dec_info = mDec[1]; req1_alu = mAlu[1]; req1_alui = mAlui[1];
        rsp0_ready = rspRdy[0];
        rsp1_ready = rspRdy[1];
    endtask

    task automatic randomOp(input int i);
        int cls;
        cls       = $urandom_range(0, 2);
        reqValid[i] = 1'b1;
        mRs1[i]   = $urandom;
        mRs2[i]   = $urandom;
        mImm[i]   = $urandom;
        mDec[i]   = {5'($urandom_range(0, 31)), 3'($urandom_range(0, 4))};
        mAlu[i]   = (cls == 0);
        mAlui[i]  = (cls == 1);
    endtask

    // One cycle with no grant expected: everything facing the ALU and responders is quiet
    task automatic idleCycle(input string tag);
        @(negedge clk);
        checkOutput({tag, "_ready0"}, req0_ready, 0);
        checkOutput({tag, "_ready1"}, req1_ready, 0);
        checkOutput({tag, "_rspv0"}, rsp0_valid, 0);
        checkOutput({tag, "_rspv1"}, rsp1_valid, 0);
        checkOutput({tag, "_exe_alu"}, exe_alu, 0);
        checkOutput({tag, "_exe_alui"}, exe_alui, 0);
        checkOutput({tag, "_op_rs1"}, op_rs1, 0);
        checkOutput({tag, "_op_rs2"}, op_rs2, 0);
        checkOutput({tag, "_exe_imm"}, exe_imm, 0);
        checkOutput({tag, "_exe_dec"}, 32'(exe_dec_info), 0);
        @(posedge clk); #1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        reqValid[0] = 1'b0; reqValid[1] = 1'b0;
        rspRdy[0] = 1'b0; rspRdy[1] = 1'b0;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lastGrant = 1;
    endtask

    // Full transaction from an IDLE cycle: grant, execute, respond (with optional stall)
    task automatic runTxn(input string tag, input int stall, input bit refill);
        int win;
        logic [XLEN-1:0] expRes, eRs1, eRs2, eImm;
        logic [DEC_W-1:0] eDec;
        logic eAlu, eAlui;
        if (reqValid[0] && reqValid[1]) win = (lastGrant == 1) ? 0 : 1;
        else if (reqValid[0])           win = 0;
        else                            win = 1;
        lastGrant = win;
        expRes = refResult(win);
        eRs1 = mRs1[win]; eRs2 = mRs2[win]; eImm = mImm[win];
        eDec = mDec[win]; eAlu = mAlu[win]; eAlui = mAlui[win];

        @(negedge clk);
        checkOutput({tag, "_grant0"}, req0_ready, (win == 0));
        checkOutput({tag, "_grant1"}, req1_ready, (win == 1));
        @(posedge clk); #1;
        if (refill) randomOp(win);
        else        reqValid[win] = 1'b0;
        applyStimulus();

        @(negedge clk);
        checkOutput({tag, "_exec_alu"}, exe_alu, eAlu);
        checkOutput({tag, "_exec_alui"}, exe_alui, eAlui);
        checkOutput({tag, "_exec_rs1"}, op_rs1, eRs1);
        checkOutput({tag, "_exec_rs2"}, op_rs2, eRs2);
        checkOutput({tag, "_exec_imm"}, exe_imm, eImm);
        checkOutput({tag, "_exec_dec"}, 32'(exe_dec_info), 32'(eDec));
        checkOutput({tag, "_exec_ready"}, {req1_ready, req0_ready}, 0);
        @(posedge clk); #1;
        rspRdy[win]     = (stall == 0);
        rspRdy[1 - win] = 1'($urandom_range(0, 1));
        applyStimulus();

        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            checkOutput({tag, "_rsp_valid_own"}, (win == 0) ? rsp0_valid : rsp1_valid, 1);
            checkOutput({tag, "_rsp_valid_other"}, (win == 0) ? rsp1_valid : rsp0_valid, 0);
            checkOutput({tag, "_rsp_result"}, (win == 0) ? rsp0_result : rsp1_result, expRes);
            checkOutput({tag, "_rsp_ready"}, {req1_ready, req0_ready}, 0);
            checkOutput({tag, "_rsp_exe"}, {exe_alu, exe_alui}, 0);
            @(posedge clk); #1;
            if (s + 1 == stall) begin
                rspRdy[win] = 1'b1;
                applyStimulus();
            end
        end
        rspRdy[0] = 1'b0; rspRdy[1] = 1'b0;
        applyStimulus();
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        lastGrant   = 1;
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 1'b0; mRs1[i] = '0; mRs2[i] = '0; mImm[i] = '0;
            mDec[i] = '0; mAlu[i] = 1'b0; mAlui[i] = 1'b0; rspRdy[i] = 1'b0;
        end
        rst_n = 1'b0;
        applyStimulus();
        @(posedge clk); #1;
        resetDut();
        $display("[TB] reset state");
        idleCycle("reset");

        // req0 ADD 5 + 7
        reqValid[0] = 1'b1; mRs1[0] = 32'd5; mRs2[0] = 32'd7; mImm[0] = '0;
        mDec[0] = 8'h00; mAlu[0] = 1'b1; mAlui[0] = 1'b0;
        applyStimulus();
        runTxn("add", 0, 1'b0);
        repeat (3) idleCycle("idle");

        // req1 XORI 0xFF ^ 0x0F with four backpressure cycles, req0 waiting
        randomOp(0);
        reqValid[1] = 1'b1; mRs1[1] = 32'hFF; mRs2[1] = $urandom; mImm[1] = 32'h0F;
        mDec[1] = 8'h02; mAlu[1] = 1'b0; mAlui[1] = 1'b1;
        applyStimulus();
        runTxn("xori_stall", 4, 1'b0);
        runTxn("after_stall", 0, 1'b0);

        // no-class request returns 0
        reqValid[0] = 1'b1; mRs1[0] = 32'h1234; mRs2[0] = 32'h5678; mImm[0] = 32'h9;
        mDec[0] = 8'h00; mAlu[0] = 1'b0; mAlui[0] = 1'b0;
        applyStimulus();
        runTxn("noclass", 1, 1'b0);

        // round-robin after reset with both requesters continuously valid
        resetDut();
        randomOp(0);
        randomOp(1);
        applyStimulus();
        for (int k = 0; k < 4; k++) begin
            runTxn("rr", $urandom_range(0, 1), 1'b1);
        end
        reqValid[0] = 1'b0; reqValid[1] = 1'b0;
        applyStimulus();
        idleCycle("rr_drain");

        // reset while in EXEC drops the operation
        randomOp(1);
        applyStimulus();
        @(negedge clk);
        checkOutput("rstexec_grant1", req1_ready, 1);
        @(posedge clk); #1;
        reqValid[1] = 1'b0;
        rst_n = 1'b0;
        applyStimulus();
        @(negedge clk);
        checkOutput("rstexec_in_exec_rs1", op_rs1, mRs1[1]);
        @(posedge clk); #1;
        rst_n = 1'b1;
        lastGrant = 1;
        repeat (3) idleCycle("rstexec_after");
        randomOp(1);
        applyStimulus();
        runTxn("rstexec_next", 0, 1'b0);

        // random traffic
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!reqValid[r] && ($urandom_range(0, 2) != 0)) randomOp(r);
            end
            applyStimulus();
            if (!reqValid[0] && !reqValid[1]) begin
                idleCycle("rand_idle");
            end else begin
                runTxn("rand", $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
- REQ-001: Parameter XLEN, default 32, operand and result width in bits.
- REQ-002: Parameter DEC_W, default `DECODE_INFO_LEN, decode-info vector width.
- REQ-003: clk  in  1  single clock; all state updates on rising edge.
- REQ-004: rst_n  in  1  reset, synchronous, active-low.
- REQ-005: reqN_valid  in  1  requester N (N=0,1) has an operation pending.
- REQ-006: reqN_ready  out  1  requester N operation accepted this cycle.
- REQ-007: reqN_rs1, reqN_rs2, reqN_imm  in  XLEN each  requester N operands and immediate.
- REQ-008: reqN_dec_info  in  DEC_W  requester N decode vector.
- REQ-009: reqN_alu, reqN_alui  in  1 each  requester N register-register or register-immediate class.
- REQ-010: op_rs1, op_rs2, exe_imm  out  XLEN each  shared ALU operands.
- REQ-011: exe_dec_info  out  DEC_W  shared ALU decode vector.
- REQ-012: exe_alu, exe_alui  out  1 each  shared ALU class enables.
- REQ-013: alu_result  in  XLEN  shared ALU combinational result.
- REQ-014: rspN_valid  out  1  result for requester N available.
- REQ-015: rspN_ready  in  1  requester N accepts result.
- REQ-016: rspN_result  out  XLEN  result for requester N.

Function
- REQ-017: States are IDLE, EXEC and RESP; reset state is IDLE.
- REQ-018: In IDLE, a request SHALL be granted only when at least one reqN_valid is high; reqN_ready SHALL be high for exactly the granted requester, combinationally, and only in IDLE.
- REQ-019: Arbitration: a single valid requester wins; when both are valid, the winner is the requester not granted last (round-robin); the last-grant pointer resets to 1, so req0 wins the first contention.
- REQ-020: On grant, operands, dec_info, class bits and the owner ID are registered and the state moves to EXEC.
- REQ-021: In EXEC, ALU outputs SHALL be driven from the operand registers; alu_result is captured into the result register; the state moves to RESP.
- REQ-022: Outside EXEC, op_rs1, op_rs2, exe_imm and exe_dec_info SHALL be 0, and exe_alu and exe_alui SHALL be 0.
- REQ-023: In RESP, rspN_valid is high only for the owner, and rspN_result holds the registered result stable.
- REQ-024: On rsp handshake (valid & ready), the state returns to IDLE; no new grant in that cycle.
- REQ-025: Latency: request accepted at edge N, rsp valid from cycle N+2; minimum issue interval 3 cycles.
- REQ-026: Response backpressure SHALL stall indefinitely in RESP; reqN_ready remains 0 and the result is unchanged.
- REQ-027: Requester protocol: reqN_* held stable while valid and not ready; the block need not tolerate violations.
- REQ-028: A request with reqN_alu=reqN_alui=0 SHALL be accepted and return the ALU's result for that input (0).
- REQ-029: rspN_result for non-owner is don't-care; rspN_valid for non-owner SHALL be 0.

Reset
- REQ-030: With rst_n low at an edge, the state SHALL become IDLE, the pointer 1, and all registers 0; all reqN_ready and rspN_valid go 0 and all ALU outputs go 0 from the next cycle.
- REQ-031: Reset in EXEC or RESP SHALL discard the in-flight operation without a response.

Structure
- REQ-032: The state encoding and the owner-ID type SHALL live in the shared package alu_arb_pkg; DEC_W derives from the shared define file.
- REQ-033: The 2-way round-robin grant logic SHALL be the sub-module rr_arb2 (inputs: valid pair, pointer; output: one-hot grant).
- REQ-034: The ALU itself SHALL be instantiated outside this block.

Verification
- REQ-035: req0 ADD with rs1=5, rs2=7, rsp0_ready=1 -> req0_ready at cycle 0, exe_alu=1 at cycle 1, rsp0_valid with result 12 at cycle 2, IDLE at cycle 3.
- REQ-036: After reset, req0 and req1 are both valid -> req0 granted first; req1 is granted on the next IDLE; with both continuously valid, grants alternate 0,1,0,1.
- REQ-037: req1 XORI with rs1=0xFF, imm=0x0F, and rsp1_ready held 0 for 4 cycles -> rsp1_valid and result 0xF0 stable throughout, req0_ready stays 0, then handshake returns to IDLE.
- REQ-038: rst_n low in EXEC -> no rsp_valid afterwards; state IDLE; the next req1 is granted normally.
- REQ-039: Idle, no requests -> exe_alu, exe_alui and all operand outputs are 0 every cycle.
